// File: rtl/pll_lock_blinker.sv
// Qualifies the PLL lock status and then divides refclk to blink an LED.
// Lock drops seen while running are latched and counted for debug.
module pll_lock_blinker #(
  parameter int CLK_FREQ_HZ   = 100000000,
  parameter int BLINK_HZ      = 1,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  lock_err_clr,
  output logic                  led,
  output logic                  tick,
  output logic                  running,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int HALF  = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [SET_W-1:0]      SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

  if (HALF < 2) begin : g_half_chk
    $error("pll_lock_blinker: CLK_FREQ_HZ/(2*BLINK_HZ) must be at least 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_settle_chk
    $error("pll_lock_blinker: SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    sync1_r;
  logic                    lk_sync_r;
  logic [SET_W-1:0]        settle_cnt_r;
  logic [DIV_W-1:0]        div_cnt_r;
  logic                    led_r;
  logic                    tick_r;
  logic                    running_r;
  logic                    lock_lost_r;
  logic [LOSS_CNT_W-1:0]   loss_cnt_r;
  logic                    loss_evt_s;
  logic                    wrap_s;

  // Lock synchroniser and FSM state register.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      sync1_r   <= 1'b0;
      lk_sync_r <= 1'b0;
      state_r   <= WAIT_LOCK;
    end else begin
      sync1_r   <= pll_locked;
      lk_sync_r <= sync1_r;
      state_r   <= state_nxt_s;
    end
  end

  // Next-state decode plus the loss and divider-wrap events.
  always_comb begin
    state_nxt_s = state_r;
    loss_evt_s  = 1'b0;
    wrap_s      = 1'b0;
    case (state_r)
      WAIT_LOCK: begin
        if (lk_sync_r) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      SETTLE: begin
        if (!lk_sync_r) begin
          state_nxt_s = WAIT_LOCK;
        end else if (settle_cnt_r == SET_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      RUN: begin
        if (!lk_sync_r) begin
          state_nxt_s = WAIT_LOCK;
          loss_evt_s  = 1'b1;
        end else begin
          state_nxt_s = RUN;
          wrap_s      = (div_cnt_r == DIV_LAST);
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
      end
    endcase
  end

  // Counters and registered outputs; every counter restarts from zero on state entry.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      settle_cnt_r <= '0;
      div_cnt_r    <= '0;
      led_r        <= 1'b0;
      tick_r       <= 1'b0;
      running_r    <= 1'b0;
      lock_lost_r  <= 1'b0;
      loss_cnt_r   <= '0;
    end else begin
      if ((state_nxt_s == SETTLE) && (state_r == SETTLE)) begin
        settle_cnt_r <= settle_cnt_r + 1'b1;
      end else begin
        settle_cnt_r <= '0;
      end

      if ((state_nxt_s == RUN) && (state_r == RUN)) begin
        div_cnt_r <= wrap_s ? '0 : (div_cnt_r + 1'b1);
      end else begin
        div_cnt_r <= '0;
      end

      if (state_nxt_s == RUN) begin
        led_r <= wrap_s ? ~led_r : led_r;
      end else begin
        led_r <= 1'b0;
      end

      tick_r    <= (state_nxt_s == RUN) && wrap_s && !led_r;
      running_r <= (state_nxt_s == RUN);

      if (loss_evt_s) begin
        lock_lost_r <= 1'b1;
      end else if (lock_err_clr) begin
        lock_lost_r <= 1'b0;
      end else begin
        lock_lost_r <= lock_lost_r;
      end

      if (loss_evt_s && (loss_cnt_r != LOSS_MAX)) begin
        loss_cnt_r <= loss_cnt_r + 1'b1;
      end else begin
        loss_cnt_r <= loss_cnt_r;
      end
    end
  end

  assign led       = led_r;
  assign tick      = tick_r;
  assign running   = running_r;
  assign lock_lost = lock_lost_r;
  assign loss_cnt  = loss_cnt_r;

endmodule

// File: tb/tb_pll_lock_blinker.sv
// Scoreboard bench for pll_lock_blinker: a cycle model pushes expected outputs
// each edge, which are popped and compared just after the edge.
module tb_pll_lock_blinker;

  localparam int CLK_FREQ_HZ   = 20;
  localparam int BLINK_HZ      = 1;
  localparam int SETTLE_CYCLES = 4;
  localparam int LOSS_CNT_W    = 8;
  localparam int HALF          = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int LIMIT         = 40;

  logic       refclk       = 1'b0;
  logic       rst          = 1'b1;
  logic       pll_locked   = 1'b0;
  logic       lock_err_clr = 1'b0;
  logic       led;
  logic       tick;
  logic       running;
  logic       lock_lost;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  logic m_s1, m_lk, m_led, m_tick, m_run, m_lost;
  int   m_st, m_settle, m_age, m_cnt;

  pll_lock_blinker #(
    .CLK_FREQ_HZ  (CLK_FREQ_HZ),
    .BLINK_HZ     (BLINK_HZ),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .LOSS_CNT_W   (LOSS_CNT_W)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .lock_err_clr(lock_err_clr),
    .led         (led),
    .tick        (tick),
    .running     (running),
    .lock_lost   (lock_lost),
    .loss_cnt    (loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_lk = 1'b0; m_led = 1'b0; m_tick = 1'b0; m_run = 1'b0; m_lost = 1'b0;
    m_st = 0; m_settle = 0; m_age = 0; m_cnt = 0;
  endtask

  // State codes: 0 waiting for lock, 1 settling, 2 running.
  task automatic model_update();
    logic lk_old;
    logic loss;
    lk_old = m_lk;
    m_lk   = m_s1;
    m_s1   = pll_locked;
    loss   = 1'b0;
    case (m_st)
      0: begin
        if (lk_old) begin
          m_st = 1;
          m_settle = 0;
        end
      end
      1: begin
        if (!lk_old) m_st = 0;
        else if (m_settle == SETTLE_CYCLES - 1) begin
          m_st = 2; m_age = 0; m_run = 1'b1; m_led = 1'b0; m_tick = 1'b0;
        end else m_settle++;
      end
      default: begin
        if (!lk_old) begin
          loss = 1'b1; m_st = 0; m_run = 1'b0; m_led = 1'b0; m_tick = 1'b0;
        end else begin
          m_age++;
          m_led  = ((m_age / HALF) % 2) == 1;
          m_tick = (m_age % (2 * HALF)) == HALF;
        end
      end
    endcase
    if (loss) begin
      m_lost = 1'b1;
      if (m_cnt != 255) m_cnt++;
    end else if (lock_err_clr) m_lost = 1'b0;
  endtask

  task automatic clk_step();
    logic [11:0] e;
    @(posedge refclk);
    if (!rst) model_reset();
    else model_update();
    exp_q.push_back({m_led, m_tick, m_run, m_lost, m_cnt[7:0]});
    #1;
    e = exp_q.pop_front();
    check_val("outs", {20'd0, led, tick, running, lock_lost, loss_cnt}, {20'd0, e});
  endtask

  task automatic wait_running(output int n);
    n = 0;
    while (running !== 1'b1 && n < LIMIT) begin
      clk_step();
      n++;
    end
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (led !== 1'b1 && n < LIMIT) begin
      clk_step();
      n++;
    end
  endtask

  initial begin
    int n;
    int gap;
    int nticks;
    model_reset();
    #1;
    rst = 1'b0;
    pll_locked = 1'b1;
    #1;
    check_val("rst_outs", {20'd0, led, tick, running, lock_lost, loss_cnt}, 32'd0);
    repeat (50) clk_step();
    rst = 1'b1;
    wait_running(n);
    check_val("startup_edges", n, 32'd7);

    wait_led(n);
    check_val("first_rise", n, HALF);
    check_val("first_tick", {31'd0, tick}, 32'd1);
    gap = 0;
    nticks = 0;
    for (int i = 0; i < 10 * HALF; i++) begin
      clk_step();
      gap++;
      if (tick === 1'b1) begin
        check_val("tick_gap", gap, 2 * HALF);
        gap = 0;
        nticks++;
      end
    end
    check_val("tick_count", nticks, 32'd5);

    // Loss while led is high.
    wait_led(n);
    pll_locked = 1'b0;
    n = 0;
    while (running === 1'b1 && n < LIMIT) begin
      clk_step();
      n++;
    end
    check_val("loss_edges", n, 32'd3);
    check_val("loss_led", {31'd0, led}, 32'd0);
    check_val("loss_flag", {31'd0, lock_lost}, 32'd1);
    check_val("loss_cnt1", {24'd0, loss_cnt}, 32'd1);
    pll_locked = 1'b1;
    wait_running(n);
    check_val("relock_edges", n, 32'd7);
    check_val("relock_led", {31'd0, led}, 32'd0);
    wait_led(n);
    check_val("relock_rise", n, HALF);

    for (int i = 0; i < 259; i++) begin
      pll_locked = 1'b0;
      repeat (3) clk_step();
      pll_locked = 1'b1;
      wait_running(n);
      check_val("sat_relock", n, 32'd7);
    end
    check_val("loss_sat", {24'd0, loss_cnt}, 32'd255);

    lock_err_clr = 1'b1;
    clk_step();
    lock_err_clr = 1'b0;
    check_val("clr_flag", {31'd0, lock_lost}, 32'd0);
    check_val("clr_cnt", {24'd0, loss_cnt}, 32'd255);

    pll_locked = 1'b0;
    repeat (2) clk_step();
    lock_err_clr = 1'b1;
    clk_step();
    lock_err_clr = 1'b0;
    check_val("set_wins", {31'd0, lock_lost}, 32'd1);
    check_val("set_wins_run", {31'd0, running}, 32'd0);

    // Asynchronous reset between edges while running.
    pll_locked = 1'b1;
    wait_running(n);
    repeat (7) clk_step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_val("async_rst", {20'd0, led, tick, running, lock_lost, loss_cnt}, 32'd0);
    repeat (5) clk_step();
    rst = 1'b1;
    wait_running(n);
    check_val("async_startup", n, 32'd7);

    // One-cycle lock glitch during the settle window.
    rst = 1'b0;
    pll_locked = 1'b0;
    repeat (3) clk_step();
    rst = 1'b1;
    repeat (2) clk_step();
    pll_locked = 1'b1;
    repeat (2) clk_step();
    pll_locked = 1'b0;
    clk_step();
    pll_locked = 1'b1;
    wait_running(n);
    check_val("glitch_edges", n, 32'd7);
    check_val("glitch_flag", {31'd0, lock_lost}, 32'd0);
    check_val("glitch_cnt", {24'd0, loss_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
